dot_accum_seq: RTL and testbench

DOT_ACCUM_SEQ -- requirements
Module: dot_accum_seq

---
 rtl/dot_accum_seq.sv | 155 +++++++++++++++
 tb/tb_dot_accum_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accum_seq.sv
// dot_accum_seq: sequential signed dot product of len X/Y pairs into an ACC_W accumulator.
// Latency: finished pulses the cycle after the last accepted pair (cycle after start when len=0).
// Backpressure: in_ready is high only while accumulating; pairs are taken on in_valid && in_ready.
// Optional build macro DOT_ACCUM_SATURATE_EN: overflowing additions clamp instead of wrapping.
module dot_accum_seq #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              finished,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Clamp limits used only when saturation is compiled in.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state;
  state_t state_nxt;

  logic signed [ACC_W-1:0]    acc;
  logic [LEN_W-1:0]           remaining;

  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] y_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum_raw;
  logic signed [ACC_W-1:0]    acc_nxt;
  logic                       add_ovf;

  logic start_acc;
  logic accept;
  logic last_pair;

  // Handshake qualifiers: start only counts in IDLE, pairs only count in ACCUM.
  assign start_acc = (state == S_IDLE) && start;
  assign accept    = (state == S_ACCUM) && in_valid;
  assign last_pair = accept && (remaining == LEN_W'(1));

  // Full-precision signed product, sign-extended to accumulator width.
  assign x_ext    = (2*DATA_W)'($signed(X));
  assign y_ext    = (2*DATA_W)'($signed(Y));
  assign prod     = x_ext * y_ext;
  assign prod_ext = ACC_W'(prod);
  assign sum_raw  = acc + prod_ext;

  // Two's-complement overflow: like-signed operands producing a result of the other sign.
  assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef DOT_ACCUM_SATURATE_EN
  // On overflow both operands share the sign of acc, so acc's sign picks the clamp rail.
  assign acc_nxt = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  // Wrap-around accumulation; the sticky flag still records the overflow.
  assign acc_nxt = sum_raw;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (last_pair) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    finished = 1'b0;
    case (state)
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        busy     = 1'b1;
        finished = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: clear on start, accumulate per accepted pair, publish the sum on the last pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      remaining <= '0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (start_acc) begin
      acc       <= '0;
      remaining <= len;
      overflow  <= 1'b0;
      // Zero-length operations complete immediately with an empty sum.
      if (len == '0) begin
        result <= '0;
      end
    end else if (accept) begin
      acc       <= acc_nxt;
      remaining <= remaining - LEN_W'(1);
      if (add_ovf) begin
        overflow <= 1'b1;
      end
      if (last_pair) begin
        result <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dot_accum_seq.sv
// Testbench for dot_accum_seq with DATA_W=8, ACC_W=16, LEN_W=4.
// Table-driven operations plus hand sequences for reset mid-op and start during ACCUM.
// Expected values are hand-computed constants; saturating build selected by the same macro.
module tb_dot_accum_seq;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              finished;
  logic [ACC_W-1:0]  result;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  dot_accum_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .X(X), .Y(Y),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .finished(finished), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [LEN_W-1:0]  n;
    logic [15:0][7:0]  xs;
    logic [15:0][7:0]  ys;
    int                gap;
    logic [ACC_W-1:0]  exp_res;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one operation: start, feed pairs with optional idle gaps, check the DONE cycle.
  task automatic run_op(input vec_t v);
    start = 1'b1;
    len   = v.n;
    tick();
    start = 1'b0;
    if (v.n == 0) begin
      chk({v.name, " finished"}, 32'(finished), 32'd1);
      chk({v.name, " in_ready"}, 32'(in_ready), 32'd0);
    end else begin
      chk({v.name, " busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < int'(v.n); i++) begin
        if (i > 0) begin
          for (int g = 0; g < v.gap; g++) begin
            in_valid = 1'b0;
            X = 8'h55;
            Y = 8'h55;
            tick();
            chk({v.name, " gap finished"}, 32'(finished), 32'd0);
          end
        end
        chk({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        X = v.xs[i];
        Y = v.ys[i];
        tick();
        in_valid = 1'b0;
        if (i < int'(v.n) - 1) begin
          chk({v.name, " early finished"}, 32'(finished), 32'd0);
        end
      end
      chk({v.name, " finished"}, 32'(finished), 32'd1);
      chk({v.name, " done in_ready"}, 32'(in_ready), 32'd0);
    end
    chk({v.name, " result"}, 32'(result), 32'(v.exp_res));
    chk({v.name, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
    tick();
    chk({v.name, " pulse end"}, 32'(finished), 32'd0);
    chk({v.name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;

    // Basic 1..3 x 4..6 dot product, back-to-back pairs.
    vecs[0] = '{name: "dot3", n: 4'd3, xs: '0, ys: '0, gap: 0, exp_res: 16'h0020, exp_ovf: 1'b0};
    vecs[0].xs[0] = 8'd1; vecs[0].xs[1] = 8'd2; vecs[0].xs[2] = 8'd3;
    vecs[0].ys[0] = 8'd4; vecs[0].ys[1] = 8'd5; vecs[0].ys[2] = 8'd6;
    // Zero-length op.
    vecs[1] = '{name: "len0", n: 4'd0, xs: '0, ys: '0, gap: 0, exp_res: 16'h0000, exp_ovf: 1'b0};
    // Mixed signs with two idle cycles between pairs: -15 + -14 = -29.
    vecs[2] = '{name: "gap2", n: 4'd2, xs: '0, ys: '0, gap: 2, exp_res: 16'hFFE3, exp_ovf: 1'b0};
    vecs[2].xs[0] = 8'hFD; vecs[2].xs[1] = 8'd7;
    vecs[2].ys[0] = 8'd5;  vecs[2].ys[1] = 8'hFE;
    // Positive overflow: 3 * 16129 = 48387.
`ifdef DOT_ACCUM_SATURATE_EN
    vecs[3] = '{name: "ovf_pos", n: 4'd3, xs: '0, ys: '0, gap: 0, exp_res: 16'h7FFF, exp_ovf: 1'b1};
`else
    vecs[3] = '{name: "ovf_pos", n: 4'd3, xs: '0, ys: '0, gap: 0, exp_res: 16'hBD03, exp_ovf: 1'b1};
`endif
    for (int i = 0; i < 3; i++) begin
      vecs[3].xs[i] = 8'd127;
      vecs[3].ys[i] = 8'd127;
    end
    // Near negative limit without overflow: 2 * -16256 = -32512 (0x8100).
    vecs[4] = '{name: "neg_edge", n: 4'd2, xs: '0, ys: '0, gap: 1, exp_res: 16'h8100, exp_ovf: 1'b0};
    // Negative overflow: 3 * -16256 = -48768 -> wraps to 0x4180.
`ifdef DOT_ACCUM_SATURATE_EN
    vecs[5] = '{name: "ovf_neg", n: 4'd3, xs: '0, ys: '0, gap: 0, exp_res: 16'h8000, exp_ovf: 1'b1};
`else
    vecs[5] = '{name: "ovf_neg", n: 4'd3, xs: '0, ys: '0, gap: 0, exp_res: 16'h4180, exp_ovf: 1'b1};
`endif
    for (int i = 0; i < 3; i++) begin
      vecs[4].xs[i] = 8'h80; vecs[4].ys[i] = 8'd127;
      vecs[5].xs[i] = 8'h80; vecs[5].ys[i] = 8'd127;
    end
    // Maximum length 15, products 1,2,..15 -> 120.
    vecs[6] = '{name: "maxlen", n: 4'd15, xs: '0, ys: '0, gap: 0, exp_res: 16'd120, exp_ovf: 1'b0};
    for (int i = 0; i < 15; i++) begin
      vecs[6].xs[i] = 8'(i + 1);
      vecs[6].ys[i] = 8'd1;
    end

    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    X        = '0;
    Y        = '0;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst result", 32'(result), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst finished", 32'(finished), 32'd0);

    // Valid pairs in IDLE must be ignored.
    in_valid = 1'b1;
    X = 8'd100;
    Y = 8'd100;
    tick();
    in_valid = 1'b0;
    chk("idle valid busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i]);
    end

    // Reset in the middle of a len=4 op after one accepted pair.
    start = 1'b1;
    len   = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    X = 8'd9;
    Y = 8'd9;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst finished", 32'(finished), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst overflow", 32'(overflow), 32'd0);
    tick();
    chk("midrst no pulse", 32'(finished), 32'd0);
    v = '{name: "after_rst", n: 4'd1, xs: '0, ys: '0, gap: 0, exp_res: 16'd6, exp_ovf: 1'b0};
    v.xs[0] = 8'd2;
    v.ys[0] = 8'd3;
    run_op(v);

    // start with len=5 held during a len=2 op must be ignored: 4*5 + (-3)*6 = 2.
    start = 1'b1;
    len   = 4'd2;
    tick();
    len = 4'd5;
    in_valid = 1'b1;
    X = 8'd4;
    Y = 8'd5;
    tick();
    chk("ign start finished", 32'(finished), 32'd0);
    chk("ign start in_ready", 32'(in_ready), 32'd1);
    X = 8'hFD;
    Y = 8'd6;
    tick();
    in_valid = 1'b0;
    chk("ign start done", 32'(finished), 32'd1);
    chk("ign start result", 32'(result), 32'd2);
    start = 1'b0;
    tick();
    chk("ign start idle", 32'(busy), 32'd0);
    tick();
    chk("ign start stay idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
